mem_access_unit: RTL and testbench
==================================

# mem_access_unit

Load/store initiator between the core's execute stage and the word-organised data RAM. Accepts one load or store per handshake, translates byte addresses and RV32I `funct3` widths into RAM word accesses, and returns sign/zero-extended load data. Sub-word stores use read-modify-write. Misaligned and out-of-range requests complete with an error and never touch the RAM.

## Interface
Parameters:
- `ADDR_WIDTH`, default 10: RAM word-address width. Addressable span is 4·2^ADDR_WIDTH bytes.
- `READ_LATENCY`, default 1 (legal ≥1): cycles from `mem_address` being driven until `mem_data_out` is valid to sample.

Ports:
- `clk` input 1: sole clock, rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `req_valid` input 1: request present.
- `req_ready` output 1: unit can accept a request.
- `req_write` input 1: 1 = store, 0 = load.
- `req_funct3` input 3: RV32I width/sign code.
- `req_addr` input 32: byte address.
- `req_wdata` input 32: store data, LSB-aligned.
- `resp_valid` output 1: one-cycle completion pulse.
- `resp_rdata` output 32: extended load data. It is 0 for stores and errors.
- `resp_error` output 1: request was misaligned, out of range, or had an illegal `funct3`. Qualified by `resp_valid`.
- `mem_write_enable` output 1: RAM write strobe.
- `mem_address` output ADDR_WIDTH: RAM word address.
- `mem_data_in` output 32: RAM write data.
- `mem_data_out` input 32: RAM read data.

## Operation
- **States:** IDLE, RD_WAIT, WR, RMW_WR, RESP.
- **`req_ready`:** equals (state == IDLE) && !rst.
- **Acceptance:** a request is accepted on a rising edge where `req_valid && req_ready`. All request fields are latched at that edge.
- **Legal `funct3` codes:**
  - Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - Stores: 000 SB, 001 SH, 010 SW.
  - Any other code sets error.
- **Error conditions:** any of the following sends IDLE → RESP with `resp_error`=1 and no RAM activity:
  - H access with addr[0]≠0.
  - W access with addr[1:0]≠0.
  - addr[31:ADDR_WIDTH+2]≠0.
- **Word address and byte lane:** word address = addr[ADDR_WIDTH+1:2]. Byte lane = addr[1:0], little-endian. Halfword lane = addr[1].
- **Load:** IDLE → RD_WAIT. Stay READ_LATENCY cycles, with a counter of width ≥ $clog2(READ_LATENCY+1). On the last cycle's edge, capture `mem_data_out`, select the lane, and sign-extend (LB/LH) or zero-extend (LBU/LHU). Then → RESP.
- **SW:** IDLE → WR. `mem_write_enable`=1 for exactly one cycle with `mem_data_in`=wdata. Then → RESP.
- **SB/SH:** IDLE → RD_WAIT, same as a load. Then → RMW_WR, which writes the captured word with only the addressed lane replaced by wdata[7:0] or wdata[15:0]. Then → RESP.
- **RESP:** `resp_valid`=1 for one cycle, then → IDLE. There is no response backpressure; the consumer must take the pulse.
- **RAM bus rules:**
  - `mem_address` is registered and held constant from the acceptance edge until return to IDLE.
  - In IDLE, `mem_address` keeps its last value.
  - `mem_write_enable` is 1 only in WR and RMW_WR.

## Timing
- The acceptance edge ends cycle 0. `mem_address` is valid from cycle 1.
- `resp_valid` asserts in the following cycle for each request type:
  - Load: cycle READ_LATENCY+1.
  - SW: cycle 2.
  - SB/SH: cycle READ_LATENCY+2.
  - Error: cycle 1.
- Next acceptance is possible in the cycle after RESP. Back-to-back word stores therefore sustain 1 request per 3 cycles.
- **Reset values:** state IDLE, `req_ready` 0 while `rst` is high (1 after release), `resp_valid` 0, `resp_rdata` 0, `resp_error` 0, `mem_write_enable` 0, `mem_address` 0, `mem_data_in` 0.
- **Reset mid-transaction:** `mem_write_enable` drops asynchronously, the transaction is abandoned, and no response is issued.
- `req_valid` asserted outside IDLE is ignored. It is not queued.

## Test plan
- Reset, then LW at 0x0 with RAM[0]=0x11111111, READ_LATENCY=1 → cycle 2: `resp_valid`=1, `resp_rdata`=0x11111111, `resp_error`=0.
- SW 0xDEADBEEF at 0x10, then LB at 0x13 and LBU at 0x13 → RAM[4]=0xDEADBEEF; LB returns 0xFFFFFFDE, LBU returns 0x000000DE.
- RAM[4]=0xDEADBEEF, SH 0x1234 at 0x12 → exactly one write pulse, RAM[4]=0x1234BEEF; `resp_valid` in cycle READ_LATENCY+2; then LH 0x12 → 0x00001234.
- LW at 0x6, SH at 0x1, and LW at 0x1000 (ADDR_WIDTH=10) → each gives `resp_error`=1 in cycle 1, `mem_write_enable` never asserts, RAM unchanged.
- READ_LATENCY=3, LHU at 0x2 with RAM[0]=0x8001FFFF → `resp_rdata`=0x00008001 in cycle 4; `mem_address` stable cycles 1–4.
- Assert `rst` during WR of SW → `mem_write_enable` falls immediately, no `resp_valid`; `req_ready`=1 on the first cycle after release.

Source files
------------

// File: rtl/mem_access_unit.sv
// mem_access_unit: load/store initiator between the execute stage and a
// word-organised data RAM. Byte addresses and RV32I funct3 widths become
// word accesses; sub-word stores use read-modify-write; bad requests error out
// without touching the RAM.
module mem_access_unit #(
  parameter int unsigned ADDR_WIDTH   = 10,
  parameter int unsigned READ_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [2:0]            req_funct3,
  input  logic [31:0]           req_addr,
  input  logic [31:0]           req_wdata,
  output logic                  resp_valid,
  output logic [31:0]           resp_rdata,
  output logic                  resp_error,
  output logic                  mem_write_enable,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [31:0]           mem_data_in,
  input  logic [31:0]           mem_data_out
);

  localparam int unsigned CNT_W  = $clog2(READ_LATENCY + 1);
  localparam int unsigned HI_LSB = ADDR_WIDTH + 2;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_RD_WAIT = 3'd1;
  localparam logic [2:0] ST_WR      = 3'd2;
  localparam logic [2:0] ST_RMW_WR  = 3'd3;
  localparam logic [2:0] ST_RESP    = 3'd4;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Request fields kept for the life of a transaction; only the low halfword
  // of store data is needed after acceptance (word stores write it directly).
  typedef struct packed {
    logic        write;
    logic [2:0]  funct3;
    logic [1:0]  lane;
    logic [15:0] wdata;
  } req_t;

  logic [2:0]            state, state_nxt;
  req_t                  req_q, req_nxt;
  logic [CNT_W-1:0]      lat_cnt, lat_cnt_nxt;
  logic                  resp_valid_nxt;
  logic                  resp_error_nxt;
  logic [31:0]           resp_rdata_nxt;
  logic                  mem_we_nxt;
  logic [ADDR_WIDTH-1:0] mem_address_nxt;
  logic [31:0]           mem_data_in_nxt;

  logic accept_c;
  logic legal_c;
  logic misaligned_c;
  logic out_of_range_c;
  logic req_err_c;

  // Select the addressed lane of a read word and sign/zero-extend it
  function automatic logic [31:0] load_extend(input logic [2:0]  f3,
                                              input logic [1:0]  lane,
                                              input logic [31:0] word);
    logic [7:0]  b;
    logic [15:0] h;
    case (lane)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      default: b = word[31:24];
    endcase
    h = lane[1] ? word[31:16] : word[15:0];
    case (f3)
      F3_B:    load_extend = {{24{b[7]}}, b};
      F3_H:    load_extend = {{16{h[15]}}, h};
      F3_BU:   load_extend = {24'd0, b};
      F3_HU:   load_extend = {16'd0, h};
      default: load_extend = word;
    endcase
  endfunction

  // Replace the addressed byte or halfword of a read word with store data
  function automatic logic [31:0] store_merge(input logic        is_byte,
                                              input logic [1:0]  lane,
                                              input logic [15:0] wdata,
                                              input logic [31:0] word);
    logic [31:0] w;
    w = word;
    if (is_byte) begin
      case (lane)
        2'd0:    w[7:0]   = wdata[7:0];
        2'd1:    w[15:8]  = wdata[7:0];
        2'd2:    w[23:16] = wdata[7:0];
        default: w[31:24] = wdata[7:0];
      endcase
    end else if (lane[1]) begin
      w[31:16] = wdata;
    end else begin
      w[15:0] = wdata;
    end
    return w;
  endfunction

  assign req_ready = (state == ST_IDLE) && !rst;
  assign accept_c  = req_valid && req_ready;

  // Legality, alignment and range decode of the presented request
  always_comb begin
    legal_c = 1'b0;
    case (req_funct3)
      F3_B, F3_H, F3_W: legal_c = 1'b1;
      F3_BU, F3_HU:     legal_c = !req_write;
      default:          legal_c = 1'b0;
    endcase
    misaligned_c = 1'b0;
    case (req_funct3[1:0])
      2'b01:   misaligned_c = req_addr[0];
      2'b10:   misaligned_c = |req_addr[1:0];
      default: misaligned_c = 1'b0;
    endcase
    out_of_range_c = |(req_addr >> HI_LSB);
    req_err_c      = !legal_c || misaligned_c || out_of_range_c;
  end

  // Next state and next values of all registered outputs
  always_comb begin
    state_nxt       = state;
    req_nxt         = req_q;
    lat_cnt_nxt     = lat_cnt;
    resp_valid_nxt  = 1'b0;
    resp_error_nxt  = 1'b0;
    resp_rdata_nxt  = '0;
    mem_we_nxt      = 1'b0;
    mem_address_nxt = mem_address;
    mem_data_in_nxt = mem_data_in;

    case (state)
      ST_IDLE: begin
        if (accept_c) begin
          req_nxt.write  = req_write;
          req_nxt.funct3 = req_funct3;
          req_nxt.lane   = req_addr[1:0];
          req_nxt.wdata  = req_wdata[15:0];
          if (req_err_c) begin
            state_nxt      = ST_RESP;
            resp_valid_nxt = 1'b1;
            resp_error_nxt = 1'b1;
          end else begin
            mem_address_nxt = req_addr[HI_LSB-1:2];
            if (req_write && (req_funct3[1:0] == 2'b10)) begin
              state_nxt       = ST_WR;
              mem_we_nxt      = 1'b1;
              mem_data_in_nxt = req_wdata;
            end else begin
              state_nxt   = ST_RD_WAIT;
              lat_cnt_nxt = CNT_W'(READ_LATENCY - 1);
            end
          end
        end
      end

      ST_RD_WAIT: begin
        if (lat_cnt == '0) begin
          if (req_q.write) begin
            state_nxt       = ST_RMW_WR;
            mem_we_nxt      = 1'b1;
            mem_data_in_nxt = store_merge(req_q.funct3[1:0] == 2'b00, req_q.lane,
                                          req_q.wdata, mem_data_out);
          end else begin
            state_nxt      = ST_RESP;
            resp_valid_nxt = 1'b1;
            resp_rdata_nxt = load_extend(req_q.funct3, req_q.lane, mem_data_out);
          end
        end else begin
          lat_cnt_nxt = lat_cnt - CNT_W'(1);
        end
      end

      ST_WR, ST_RMW_WR: begin
        state_nxt      = ST_RESP;
        resp_valid_nxt = 1'b1;
      end

      ST_RESP: begin
        state_nxt = ST_IDLE;
      end

      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Latched request, latency counter and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_q            <= '0;
      lat_cnt          <= '0;
      resp_valid       <= 1'b0;
      resp_error       <= 1'b0;
      resp_rdata       <= '0;
      mem_write_enable <= 1'b0;
      mem_address      <= '0;
      mem_data_in      <= '0;
    end else begin
      req_q            <= req_nxt;
      lat_cnt          <= lat_cnt_nxt;
      resp_valid       <= resp_valid_nxt;
      resp_error       <= resp_error_nxt;
      resp_rdata       <= resp_rdata_nxt;
      mem_write_enable <= mem_we_nxt;
      mem_address      <= mem_address_nxt;
      mem_data_in      <= mem_data_in_nxt;
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Testbench for mem_access_unit: two instances (read latency 1 and 3) share
// one request stream; each has its own RAM model. A spec-level model predicts
// response timing, data, write strobes and final RAM contents.
`timescale 1ns/1ps
module tb_mem_access_unit;

  localparam int unsigned AW    = 10;
  localparam int unsigned DEPTH = 1 << AW;
  localparam int          L1    = 1;
  localparam int          L3    = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        req_valid, req_write;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;

  logic          ready1, rv1, err1, we1;
  logic [31:0]   rdata1, din1, dout1;
  logic [AW-1:0] addr1;
  logic          ready3, rv3, err3, we3;
  logic [31:0]   rdata3, din3, dout3;
  logic [AW-1:0] addr3;

  mem_access_unit #(.ADDR_WIDTH(AW), .READ_LATENCY(L1)) u_dut1 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(ready1),
    .req_write(req_write), .req_funct3(req_funct3), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(rv1), .resp_rdata(rdata1),
    .resp_error(err1), .mem_write_enable(we1), .mem_address(addr1),
    .mem_data_in(din1), .mem_data_out(dout1));

  mem_access_unit #(.ADDR_WIDTH(AW), .READ_LATENCY(L3)) u_dut3 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(ready3),
    .req_write(req_write), .req_funct3(req_funct3), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(rv3), .resp_rdata(rdata3),
    .resp_error(err3), .mem_write_enable(we3), .mem_address(addr3),
    .mem_data_in(din3), .mem_data_out(dout3));

  // RAM models: combinational read for latency 1, two extra stages for latency 3
  logic [31:0]   ram1 [DEPTH];
  logic [31:0]   ram3 [DEPTH];
  logic [31:0]   ref_mem [DEPTH];
  logic          ram_clr, poke_en;
  logic [AW-1:0] poke_w;
  logic [31:0]   poke_d;
  logic [31:0]   pipe3_a, pipe3_b;

  always @(posedge clk) begin
    if (ram_clr) begin
      for (int i = 0; i < DEPTH; i++) begin
        ram1[i] <= '0;
        ram3[i] <= '0;
      end
    end else if (poke_en) begin
      ram1[poke_w] <= poke_d;
      ram3[poke_w] <= poke_d;
    end else begin
      if (we1) ram1[addr1] <= din1;
      if (we3) ram3[addr3] <= din3;
    end
  end

  assign dout1 = ram1[addr1];
  always @(posedge clk) begin
    pipe3_a <= ram3[addr3];
    pipe3_b <= pipe3_a;
  end
  assign dout3 = pipe3_b;

  // Scoreboard state
  int n_pass = 0;
  int n_chk  = 0;
  int issue_seq = 0;
  int seen_seq  = 0;
  int done_seq  = 0;
  int cyc = 0;
  logic active = 1'b0;
  logic chk_on = 1'b0;

  int            exp_lat1, exp_lat3, exp_we1, exp_we3;
  logic          exp_err, exp_upd;
  logic [31:0]   exp_rdata, exp_new;
  logic [AW-1:0] exp_word;
  logic [31:0]   last_rdata1, last_rdata3;
  logic          last_err1, last_err3;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
  endtask

  // Cycle count relative to the acceptance edge (cycle 1 follows that edge)
  always @(posedge clk) begin
    if (rst) begin
      active   = 1'b0;
      seen_seq = issue_seq;
    end else if (issue_seq != seen_seq) begin
      seen_seq = issue_seq;
      active   = 1'b1;
      cyc      = 1;
    end else if (active) begin
      if (cyc == exp_lat3 + 1) active = 1'b0;
      else cyc++;
    end
  end

  // Per-cycle comparison of both instances against the model
  always @(negedge clk) begin
    if (!rst && chk_on) begin
      check1("resp_valid_rl1", rv1, active && cyc == exp_lat1);
      check1("resp_valid_rl3", rv3, active && cyc == exp_lat3);
      check1("mem_we_rl1", we1, active && cyc == exp_we1);
      check1("mem_we_rl3", we3, active && cyc == exp_we3);
      check1("req_ready_rl1", ready1, !active || cyc > exp_lat1);
      check1("req_ready_rl3", ready3, !active || cyc > exp_lat3);
      if (active && cyc == exp_lat1) begin
        check32("resp_rdata_rl1", rdata1, exp_rdata);
        check1("resp_error_rl1", err1, exp_err);
        last_rdata1 = rdata1;
        last_err1   = err1;
      end
      if (active && cyc == exp_lat3) begin
        check32("resp_rdata_rl3", rdata3, exp_rdata);
        check1("resp_error_rl3", err3, exp_err);
        last_rdata3 = rdata3;
        last_err3   = err3;
      end
      if (active && !exp_err && cyc <= exp_lat1)
        check32("mem_address_rl1", 32'(addr1), 32'(exp_word));
      if (active && !exp_err && cyc <= exp_lat3)
        check32("mem_address_rl3", 32'(addr3), 32'(exp_word));
      if (active && cyc == exp_lat3 + 1) done_seq = seen_seq;
    end
  end

  task automatic poke(input logic [AW-1:0] w, input logic [31:0] d);
    @(negedge clk); #1;
    poke_en = 1'b1; poke_w = w; poke_d = d;
    ref_mem[w] = d;
    @(negedge clk); #1;
    poke_en = 1'b0;
  endtask

  // Issue one request, predict its outcome from the ISA rules, wait for it
  task automatic issue(input logic wr, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd, input logic abort_in_wr);
    logic        legal, err;
    int          nbytes, sh;
    logic [31:0] w, v, mask;
    legal  = wr ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    nbytes = 1 << f3[1:0];
    err    = !legal || ((a % 32'(nbytes)) != 0) || (a >= 32'(4 * DEPTH));
    sh     = 8 * int'(a[1:0]);
    w      = ref_mem[a[AW+1:2]];
    case (nbytes)
      1:       mask = 32'h0000_00FF;
      2:       mask = 32'h0000_FFFF;
      default: mask = 32'hFFFF_FFFF;
    endcase
    mask = mask << sh;
    exp_err = err; exp_word = a[AW+1:2]; exp_upd = 1'b0;
    exp_we1 = 0; exp_we3 = 0; exp_rdata = '0; exp_new = w;
    if (err) begin
      exp_lat1 = 1; exp_lat3 = 1;
    end else if (!wr) begin
      v = (w & mask) >> sh;
      if (!f3[2] && nbytes == 1 && v[7])  v = v | 32'hFFFF_FF00;
      if (!f3[2] && nbytes == 2 && v[15]) v = v | 32'hFFFF_0000;
      exp_rdata = v;
      exp_lat1 = L1 + 1; exp_lat3 = L3 + 1;
    end else begin
      exp_upd = 1'b1;
      exp_new = (w & ~mask) | ((wd << sh) & mask);
      if (nbytes == 4) begin
        exp_lat1 = 2; exp_lat3 = 2; exp_we1 = 1; exp_we3 = 1;
      end else begin
        exp_lat1 = L1 + 2; exp_lat3 = L3 + 2; exp_we1 = L1 + 1; exp_we3 = L3 + 1;
      end
    end

    @(negedge clk); #1;
    req_valid = 1'b1; req_write = wr; req_funct3 = f3; req_addr = a; req_wdata = wd;
    issue_seq++;

    if (abort_in_wr) begin
      @(posedge clk); #2;
      check1("we_in_wr_rl1", we1, 1'b1);
      check1("we_in_wr_rl3", we3, 1'b1);
      rst = 1'b1; req_valid = 1'b0;
      #1;
      check1("we_async_drop_rl1", we1, 1'b0);
      check1("we_async_drop_rl3", we3, 1'b0);
      return;
    end

    // Busy-time request with junk fields must be ignored
    @(negedge clk); #1;
    req_write = ~wr; req_funct3 = 3'b111; req_addr = 32'hFFFF_FFFF; req_wdata = ~wd;
    @(negedge clk); #1;
    req_valid = 1'b0;

    for (int i = 0; i < 40; i++) begin
      if (done_seq == issue_seq) break;
      @(negedge clk);
    end
    if (done_seq != issue_seq) begin
      n_chk++;
      $display("FAIL txn_timeout: request %0d got no completion, required one within 40 cycles", issue_seq);
    end else begin
      if (exp_upd) ref_mem[exp_word] = exp_new;
      check32("ram_rl1", ram1[exp_word], ref_mem[exp_word]);
      check32("ram_rl3", ram3[exp_word], ref_mem[exp_word]);
    end
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_funct3 = '0;
    req_addr = '0; req_wdata = '0; poke_en = 1'b0; poke_w = '0; poke_d = '0;
    ram_clr = 1'b1;
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
    repeat (2) @(negedge clk);
    #1;
    check1("rst_ready_rl1", ready1, 1'b0);
    check1("rst_ready_rl3", ready3, 1'b0);
    check1("rst_resp_valid", rv1 | rv3, 1'b0);
    check32("rst_rdata_rl1", rdata1, 32'h0);
    check32("rst_rdata_rl3", rdata3, 32'h0);
    check1("rst_error", err1 | err3, 1'b0);
    check1("rst_we", we1 | we3, 1'b0);
    check32("rst_addr_rl1", 32'(addr1), 32'h0);
    check32("rst_addr_rl3", 32'(addr3), 32'h0);
    check32("rst_din_rl1", din1, 32'h0);
    check32("rst_din_rl3", din3, 32'h0);
    ram_clr = 1'b0;
    rst = 1'b0;
    #1;
    check1("rel_ready_rl1", ready1, 1'b1);
    check1("rel_ready_rl3", ready3, 1'b1);
    chk_on = 1'b1;

    // Word load
    poke(10'd0, 32'h1111_1111);
    issue(1'b0, 3'b010, 32'h0, 32'h0, 1'b0);
    check32("lit_lw0_rl1", last_rdata1, 32'h1111_1111);
    check32("lit_lw0_rl3", last_rdata3, 32'h1111_1111);

    // Word store then signed/unsigned byte loads of the top byte
    issue(1'b1, 3'b010, 32'h10, 32'hDEAD_BEEF, 1'b0);
    check32("lit_ram4_sw", ram1[4], 32'hDEAD_BEEF);
    issue(1'b0, 3'b000, 32'h13, 32'h0, 1'b0);
    check32("lit_lb13", last_rdata1, 32'hFFFF_FFDE);
    issue(1'b0, 3'b100, 32'h13, 32'h0, 1'b0);
    check32("lit_lbu13", last_rdata3, 32'h0000_00DE);

    // Halfword read-modify-write store, then read it back
    issue(1'b1, 3'b001, 32'h12, 32'h0000_1234, 1'b0);
    check32("lit_ram4_sh_rl1", ram1[4], 32'h1234_BEEF);
    check32("lit_ram4_sh_rl3", ram3[4], 32'h1234_BEEF);
    issue(1'b0, 3'b001, 32'h12, 32'h0, 1'b0);
    check32("lit_lh12", last_rdata1, 32'h0000_1234);

    // Byte store into an odd lane
    issue(1'b1, 3'b000, 32'h21, 32'hFFFF_FFA5, 1'b0);
    check32("lit_ram8_sb", ram3[8], 32'h0000_A500);
    issue(1'b0, 3'b000, 32'h21, 32'h0, 1'b0);
    check32("lit_lb21", last_rdata3, 32'hFFFF_FFA5);

    // Error cases: misaligned, out of range, illegal funct3
    issue(1'b0, 3'b010, 32'h6, 32'h0, 1'b0);
    check1("lit_err_lw6", last_err1, 1'b1);
    issue(1'b1, 3'b001, 32'h1, 32'hFFFF_FFFF, 1'b0);
    check1("lit_err_sh1", last_err3, 1'b1);
    issue(1'b0, 3'b010, 32'h1000, 32'h0, 1'b0);
    check1("lit_err_lw1000", last_err1, 1'b1);
    issue(1'b0, 3'b011, 32'h0, 32'h0, 1'b0);
    issue(1'b1, 3'b100, 32'h20, 32'h1234_5678, 1'b0);
    check32("lit_ram0_after_err", ram1[0], 32'h1111_1111);

    // Halfword loads of the upper lane, unsigned and signed
    poke(10'd0, 32'h8001_FFFF);
    issue(1'b0, 3'b101, 32'h2, 32'h0, 1'b0);
    check32("lit_lhu2_rl3", last_rdata3, 32'h0000_8001);
    issue(1'b0, 3'b001, 32'h2, 32'h0, 1'b0);
    check32("lit_lh2", last_rdata1, 32'hFFFF_8001);
    issue(1'b0, 3'b000, 32'h1, 32'h0, 1'b0);
    check32("lit_lb1", last_rdata1, 32'hFFFF_FFFF);

    // Reset during the write cycle of a word store
    issue(1'b1, 3'b010, 32'h10, 32'h55AA_55AA, 1'b1);
    repeat (2) @(negedge clk);
    #1;
    rst = 1'b0;
    #1;
    check1("post_rst_ready_rl1", ready1, 1'b1);
    check1("post_rst_ready_rl3", ready3, 1'b1);
    check32("post_rst_addr_rl1", 32'(addr1), 32'h0);
    repeat (4) @(negedge clk);
    check32("lit_ram4_after_abort", ram1[4], 32'h1234_BEEF);
    issue(1'b0, 3'b010, 32'h10, 32'h0, 1'b0);
    check32("lit_lw10_after_rst", last_rdata3, 32'h1234_BEEF);

    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
